// File: rtl/fht_addr_gen_if.sv
// Sequencer-to-datapath bundle for fht_addr_gen: start/busy/done framing plus RAM/ROM strobes and addresses.
// The master side is the address generator; the slave side is the RAM/butterfly consumer.
interface fht_addr_gen_if #(
    parameter int A_BIT = 10
);
    logic               iSTART;
    logic               oBUSY;
    logic               oDONE;
    logic [4:0]         oSTAGE;
    logic               oBANK;
    logic               oRD_EN_12;
    logic [A_BIT-1:0]   oRD_ADDR_1;
    logic [A_BIT-1:0]   oRD_ADDR_2;
    logic [A_BIT-2:0]   oCOEF_ADDR;
    logic               oRD_EN_0;
    logic [A_BIT-1:0]   oRD_ADDR_0;
    logic               oWR_EN;
    logic [A_BIT-1:0]   oWR_ADDR_0;
    logic [A_BIT-1:0]   oWR_ADDR_1;

    modport master (
        input  iSTART,
        output oBUSY, oDONE, oSTAGE, oBANK,
        output oRD_EN_12, oRD_ADDR_1, oRD_ADDR_2, oCOEF_ADDR,
        output oRD_EN_0, oRD_ADDR_0,
        output oWR_EN, oWR_ADDR_0, oWR_ADDR_1
    );

    modport slave (
        output iSTART,
        input  oBUSY, oDONE, oSTAGE, oBANK,
        input  oRD_EN_12, oRD_ADDR_1, oRD_ADDR_2, oCOEF_ADDR,
        input  oRD_EN_0, oRD_ADDR_0,
        input  oWR_EN, oWR_ADDR_0, oWR_ADDR_1
    );
endinterface

// File: rtl/fht_addr_gen.sv
// Radix-2 FHT operand sequencer: one butterfly/cycle, x0 one cycle after x1/x2/coef, write-back 3 cycles after issue;
// no backpressure, stages ping-pong between banks. FHT_BITREV_EN bit-reverses stage-0 reads for natural-order input.
module fht_addr_gen #(
    parameter int A_BIT  = 10,
    parameter int RD_LAT = 1
) (
    input  logic          iCLK,
    input  logic          iRESET,
    fht_addr_gen_if.master bus
);
    localparam int                CW      = A_BIT - 1;
    localparam int                WR_DLY  = RD_LAT + 2;
    localparam logic [A_BIT-1:0]  ONE     = 1;
    localparam logic [A_BIT-2:0]  J_LAST  = '1;
    localparam logic [4:0]        S_LAST  = 5'(A_BIT - 1);
    localparam logic [3:0]        DC_LAST = 4'(WR_DLY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [4:0]       s_q, s_d;
    logic [A_BIT-2:0] j_q, j_d;
    logic [3:0]       dc_q, dc_d;

    logic             issue;
    logic [A_BIT-1:0] jx, h, msk, k, g, x0, x1, x2, rx0, rx1, rx2;
    logic [CW-1:0]    coef;

    logic             rd_en_12_q;
    logic [A_BIT-1:0] ra1_q, ra2_q, x0_q, ra0_q, wa0_q, wa1_q;
    logic [CW-1:0]    coef_q;
    logic [WR_DLY-1:0] wv_q;
    logic [A_BIT-1:0] wa0_p_q [WR_DLY];
    logic [A_BIT-1:0] wa1_p_q [WR_DLY];

`ifdef FHT_BITREV_EN
    function automatic logic [A_BIT-1:0] brev(input logic [A_BIT-1:0] a);
        for (int i = 0; i < A_BIT; i++) begin
            brev[i] = a[A_BIT-1-i];
        end
    endfunction
`endif

    always_ff @(posedge iCLK) begin : p_state
        if (!iRESET) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            j_q     <= '0;
            dc_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            dc_q    <= dc_d;
        end
    end

    always_comb begin : p_next
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        dc_d    = dc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.iSTART) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            ST_RUN: begin
                if (j_q == J_LAST) begin
                    state_d = ST_DRAIN;
                    dc_d    = '0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Hold off the next stage until every write of this one has landed.
                if (dc_q == DC_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        s_d     = s_q + 5'd1;
                        j_d     = '0;
                    end
                end else begin
                    dc_d = dc_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                j_d     = '0;
            end
        endcase
    end

    always_comb begin : p_out
        bus.oBUSY = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        bus.oDONE = (state_q == ST_DONE);
        issue     = (state_d == ST_RUN);
        // Addresses are derived from next-state so the registered outputs line up with the RUN cycle.
        jx   = {1'b0, j_d};
        h    = ONE << s_d;
        msk  = h - ONE;
        k    = jx & msk;
        g    = (jx >> s_d) << (s_d + 5'd1);
        x0   = g + k;
        x1   = x0 + h;
        x2   = g + h + ((h - k) & msk);
        coef = CW'(k << (S_LAST - s_d));
        rx0  = x0;
        rx1  = x1;
        rx2  = x2;
`ifdef FHT_BITREV_EN
        if (s_d == 5'd0) begin
            rx0 = brev(x0);
            rx1 = brev(x1);
            rx2 = brev(x2);
        end
`endif
    end

    always_ff @(posedge iCLK) begin : p_dp
        if (!iRESET) begin
            rd_en_12_q <= 1'b0;
            ra1_q      <= '0;
            ra2_q      <= '0;
            coef_q     <= '0;
            x0_q       <= '0;
            ra0_q      <= '0;
            wa0_q      <= '0;
            wa1_q      <= '0;
            wv_q       <= '0;
            for (int i = 0; i < WR_DLY; i++) begin
                wa0_p_q[i] <= '0;
                wa1_p_q[i] <= '0;
            end
        end else begin
            rd_en_12_q <= issue;
            if (issue) begin
                ra1_q  <= rx1;
                ra2_q  <= rx2;
                coef_q <= coef;
                x0_q   <= rx0;
                wa0_q  <= x0;
                wa1_q  <= x1;
            end
            ra0_q      <= x0_q;
            wv_q       <= {wv_q[WR_DLY-2:0], rd_en_12_q};
            wa0_p_q[0] <= wa0_q;
            wa1_p_q[0] <= wa1_q;
            for (int i = 1; i < WR_DLY; i++) begin
                wa0_p_q[i] <= wa0_p_q[i-1];
                wa1_p_q[i] <= wa1_p_q[i-1];
            end
        end
    end

    assign bus.oSTAGE     = s_q;
    assign bus.oBANK      = s_q[0];
    assign bus.oRD_EN_12  = rd_en_12_q;
    assign bus.oRD_ADDR_1 = ra1_q;
    assign bus.oRD_ADDR_2 = ra2_q;
    assign bus.oCOEF_ADDR = coef_q;
    assign bus.oRD_EN_0   = wv_q[0];
    assign bus.oRD_ADDR_0 = ra0_q;
    assign bus.oWR_EN     = wv_q[WR_DLY-1];
    assign bus.oWR_ADDR_0 = wa0_p_q[WR_DLY-1];
    assign bus.oWR_ADDR_1 = wa1_p_q[WR_DLY-1];
endmodule
